// File: rtl/square_finder.sv
// square_finder: sequential integer squarer.
// Builds root^2 by summing the first `root` odd numbers (1 + 3 + 5 + ...),
// the same odd-increment recurrence used by the square-root finder, so the
// two blocks can be chained for a round-trip check.
// Controller and datapath share one module, with a go/busy/done handshake.
// W must be at least 2 so that the odd term can be zero-extended to 2W bits.

module square_finder #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           go,
    input  logic [W-1:0]   root,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] sq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   n_q;
    logic [W-1:0]   cnt_q;
    logic [W:0]     del_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] sq_q;
    logic           busy_q;
    logic           done_q;

    // Controller and datapath: capture the operand, add odd terms until the count reaches the root, publish the sum.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= IDLE;
            n_q    <= '0;
            cnt_q  <= '0;
            del_q  <= '0;
            acc_q  <= '0;
            sq_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        n_q    <= root;
                        acc_q  <= '0;
                        del_q  <= (W+1)'(1);
                        cnt_q  <= '0;
                        state  <= ADD;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                ADD: begin
                    if (cnt_q == n_q) begin
                        sq_q   <= acc_q;
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        acc_q <= acc_q + {{(W-1){1'b0}}, del_q};
                        del_q <= del_q + (W+1)'(2);
                        cnt_q <= cnt_q + W'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sq   = sq_q;

endmodule

// File: tb/tb_square_finder.sv
// tb_square_finder: directed self-checking bench for square_finder.
// A W=4 instance covers the handshake corners; a W=6 instance covers a
// wider operand with a few hand-picked roots.

module tb_square_finder;

    logic        clk;
    logic        clr;
    logic        go;
    logic [3:0]  root;
    logic        busy;
    logic        done;
    logic [7:0]  sq;

    logic        go6;
    logic [5:0]  root6;
    logic        busy6;
    logic        done6;
    logic [11:0] sq6;

    int compareCount;
    int mismatchCount;
    int cycle;

    square_finder #(.W(4)) dut (
        .clk  (clk),
        .clr  (clr),
        .go   (go),
        .root (root),
        .busy (busy),
        .done (done),
        .sq   (sq)
    );

    square_finder #(.W(6)) dut6 (
        .clk  (clk),
        .clr  (clr),
        .go   (go6),
        .root (root6),
        .busy (busy6),
        .done (done6),
        .sq   (sq6)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge count, used to measure spacing between done pulses.
    always @(posedge clk) cycle <= cycle + 1;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One complete W=4 operation: accept, scramble root while busy, wait for done, verify result and timing.
    task automatic applyStimulus(input logic [3:0] r, input int expSq, input string tag);
        int lat;
        int busyCnt;
        bit seen;
        @(negedge clk);
        root = r;
        go   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go      = 1'b0;
        root    = ~r;
        busyCnt = busy ? 1 : 0;
        lat     = 0;
        seen    = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy) busyCnt++;
            if (done) seen = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_sq"}, 32'(sq), 32'(expSq));
        checkOutput({tag, "_latency"}, 32'(lat), 32'(r) + 32'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_done_width"}, 32'(done), 32'd0);
        checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
        checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), 32'(r) + 32'd2);
        checkOutput({tag, "_sq_hold"}, 32'(sq), 32'(expSq));
    endtask

    // One complete W=6 operation on the wide instance.
    task automatic runSix(input logic [5:0] r, input int expSq, input string tag);
        int lat;
        bit seen;
        @(negedge clk);
        root6 = r;
        go6   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go6  = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done6) seen = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_sq"}, 32'(sq6), 32'(expSq));
        checkOutput({tag, "_latency"}, 32'(lat), 32'(r) + 32'd1);
    endtask

    // Directed sequence: reset, zero, maximum, mid-run clear, busy rejection, back-to-back, sweep, wide operands.
    initial begin
        int lat;
        int nDone;
        int extraDone;
        int doneCyc [2];
        bit seen;

        compareCount  = 0;
        mismatchCount = 0;
        cycle         = 0;
        clr   = 1'b0;
        go    = 1'b0;
        root  = '0;
        go6   = 1'b0;
        root6 = '0;

        #3;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_sq", 32'(sq), 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;

        applyStimulus(4'd0, 0, "zero");
        applyStimulus(4'd15, 225, "max");
        repeat (3) @(negedge clk);
        checkOutput("max_sq_long_hold", 32'(sq), 32'd225);

        // Clear asserted three cycles into a root=12 run.
        @(negedge clk);
        root = 4'd12;
        go   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        repeat (3) @(posedge clk);
        #2 clr = 1'b0;
        #1;
        checkOutput("clr_busy", 32'(busy), 32'd0);
        checkOutput("clr_done", 32'(done), 32'd0);
        checkOutput("clr_sq", 32'(sq), 32'd0);
        @(negedge clk);
        clr = 1'b1;
        applyStimulus(4'd12, 144, "after_clr");

        // Busy rejection: second go with a different root two cycles into a root=9 run.
        @(negedge clk);
        root = 4'd9;
        go   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go  = 1'b0;
        lat = 0;
        @(posedge clk);
        lat++;
        @(negedge clk);
        go   = 1'b1;
        root = 4'd3;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        go = 1'b0;
        checkOutput("reject_done_seen", 32'(seen), 32'd1);
        checkOutput("reject_latency", 32'(lat), 32'd10);
        checkOutput("reject_sq", 32'(sq), 32'd81);
        extraDone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) extraDone++;
        end
        checkOutput("reject_no_second_done", 32'(extraDone), 32'd0);
        checkOutput("reject_sq_hold", 32'(sq), 32'd81);

        // Back-to-back with go held high; root switches 5 -> 7 at the first done.
        // DONE ignores go, so the second accept lands one edge after the return to IDLE.
        @(negedge clk);
        root  = 4'd5;
        go    = 1'b1;
        nDone = 0;
        doneCyc[0] = 0;
        doneCyc[1] = 0;
        for (int i = 0; i < 60 && nDone < 2; i++) begin
            @(negedge clk);
            if (done) begin
                doneCyc[nDone] = cycle;
                checkOutput((nDone == 0) ? "b2b_first_sq" : "b2b_second_sq", 32'(sq), (nDone == 0) ? 32'd25 : 32'd49);
                nDone++;
                root = 4'd7;
            end
        end
        go = 1'b0;
        checkOutput("b2b_done_count", 32'(nDone), 32'd2);
        checkOutput("b2b_done_gap", 32'(doneCyc[1] - doneCyc[0]), 32'd10);
        repeat (3) @(negedge clk);

        for (int r = 0; r < 16; r++) begin
            applyStimulus(4'(r), r * r, $sformatf("sweep%0d", r));
        end

        runSix(6'd63, 3969, "w6_max");
        runSix(6'd37, 1369, "w6_37");
        runSix(6'd1, 1, "w6_one");
        runSix(6'd50, 2500, "w6_50");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
